// File: rtl/mac_neuron_serial.sv
// Time-multiplexed neuron: one activation per cycle is multiplied by a stored weight and summed
// with a bias, then shifted, activated and clamped; the result is held on a valid/ready output.
module mac_neuron_serial #(
  parameter int N_IN     = 15,
  parameter int DATA_W   = 8,
  parameter int WGT_W    = 8,
  parameter int ACC_W    = 24,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 5,
  parameter int ACT_MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(N_IN+1)-1:0]  cfg_addr,
  input  logic [WGT_W-1:0]           cfg_data,
  output logic                       cfg_ready,
  input  logic                       x_valid,
  input  logic [DATA_W-1:0]          x_data,
  output logic                       x_ready,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  input  logic                       out_ready,
  output logic                       busy
);
  // state | meaning
  // MAC   | accept samples, accumulate bias + w[idx]*x
  // ACT   | shift, activate and clamp accumulator into out_data
  // OUT   | hold result until out_ready
  localparam int IDX_W  = $clog2(N_IN);
  localparam int AW     = $clog2(N_IN+1);
  localparam int PROD_W = DATA_W + WGT_W;

  localparam logic [1:0] ST_MAC = 2'd0;
  localparam logic [1:0] ST_ACT = 2'd1;
  localparam logic [1:0] ST_OUT = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_IN-1);
  localparam logic [AW-1:0]    ADDR_BIAS = AW'(N_IN);

  logic [1:0]              state;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic [WGT_W-1:0]        w_mem [N_IN];
  logic [WGT_W-1:0]        bias;

  logic [WGT_W-1:0]         w_sel;
  logic signed [PROD_W-1:0] w_ext, x_ext, prod;
  logic signed [ACC_W-1:0]  acc_base, acc_next, s;
  logic [OUT_W-1:0]         act_val;
  logic                     x_take, cfg_take;

  assign busy      = (state != ST_MAC) || (idx != '0);
  assign cfg_ready = ~busy;
  assign x_ready   = (state == ST_MAC);
  assign x_take    = x_ready & x_valid;
  // a write colliding with the first sample of a frame loses to the sample
  assign cfg_take  = cfg_we & cfg_ready & ~x_take;

  assign w_sel    = w_mem[idx];
  assign w_ext    = {{DATA_W{w_sel[WGT_W-1]}}, w_sel};
  assign x_ext    = {{WGT_W{x_data[DATA_W-1]}}, x_data};
  assign prod     = w_ext * x_ext;
  assign acc_base = (idx == '0) ? {{(ACC_W-WGT_W){bias[WGT_W-1]}}, bias} : acc;
  assign acc_next = acc_base + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign s        = acc >>> SHIFT;

  always_comb begin
    act_val = s[OUT_W-1:0];
    if (ACT_MODE == 0) begin
      if (s[ACC_W-1])
        act_val = '0;
      else if (|s[ACC_W-1:OUT_W])
        act_val = '1;
    end else begin
      // out of signed range whenever the bits above the output sign bit disagree
      if (!(&s[ACC_W-1:OUT_W-1]) && (|s[ACC_W-1:OUT_W-1]))
        act_val = s[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_IN; i++) w_mem[i] <= '0;
      bias <= '0;
    end else if (cfg_take) begin
      if (cfg_addr == ADDR_BIAS)
        bias <= cfg_data;
      else if (cfg_addr < ADDR_BIAS)
        w_mem[cfg_addr[IDX_W-1:0]] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_MAC;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_MAC: begin
          if (x_valid) begin
            acc <= acc_next;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= ST_ACT;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_ACT: begin
          out_data  <= act_val;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_MAC;
          end
        end
        default: state <= ST_MAC;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_neuron_serial.sv
// Bench for mac_neuron_serial: ReLU and linear instances share stimulus; expected results come
// from a behavioural model pushed to queues per frame and popped when the result appears.
module tb_mac_neuron_serial;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       x_valid;
  logic [7:0] x_data;
  logic       out_ready;

  logic       cfg_ready0, x_ready0, out_valid0, busy0;
  logic       cfg_ready1, x_ready1, out_valid1, busy1;
  logic [7:0] out_data0, out_data1;

  int errors = 0;
  int checks = 0;
  int w_m [N];
  int bias_m;
  logic [7:0] exp0_q [$];
  logic [7:0] exp1_q [$];
  logic [7:0] e0, e1;
  bit ok;

  always #5 clk = ~clk;

  mac_neuron_serial #(.N_IN(N), .ACT_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready0), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready), .busy(busy0));

  mac_neuron_serial #(.N_IN(N), .ACT_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready1), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready), .busy(busy1));

  function automatic longint model_acc(input int xs [N]);
    longint a;
    logic [23:0] t;
    a = longint'(bias_m);
    for (int i = 0; i < N; i++) a += longint'(w_m[i]) * longint'(xs[i]);
    t = a[23:0];
    return {{40{t[23]}}, t};
  endfunction

  function automatic logic [7:0] act0(input longint a);
    longint s;
    s = a >>> 5;
    if (s < 0) return 8'h00;
    if (s > 255) return 8'hFF;
    return s[7:0];
  endfunction

  function automatic logic [7:0] act1(input longint a);
    longint s;
    s = a >>> 5;
    if (s > 127) return 8'h7F;
    if (s < -128) return 8'h80;
    return s[7:0];
  endfunction

  task automatic push_expect(input int xs [N]);
    longint a;
    a = model_acc(xs);
    exp0_q.push_back(act0(a));
    exp1_q.push_back(act1(a));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input int addr, input int data, input bit takes);
    cfg_we   = 1'b1;
    cfg_addr = addr[2:0];
    cfg_data = data[7:0];
    step();
    cfg_we = 1'b0;
    if (takes) begin
      if (addr == N) bias_m = data;
      else if (addr < N) w_m[addr] = data;
    end
  endtask

  task automatic send_frame(input int xs [N]);
    push_expect(xs);
    for (int i = 0; i < N; i++) begin
      x_valid = 1'b1;
      x_data  = xs[i][7:0];
      step();
    end
    x_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (out_valid0 && out_valid1) begin
        got = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic check_result(input string name);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: out_valid=%b/%b required 1/1", name, out_valid0, out_valid1);
    end
    e0 = exp0_q.pop_front();
    e1 = exp1_q.pop_front();
    checks++;
    if (out_data0 !== e0) begin
      errors++;
      $display("FAIL %s relu: got %h required %h", name, out_data0, e0);
    end
    checks++;
    if (out_data1 !== e1) begin
      errors++;
      $display("FAIL %s linear: got %h required %h", name, out_data1, e1);
    end
  endtask

  task automatic load_weights(input int w0, input int w1, input int w2, input int w3, input int b);
    write_cfg(0, w0, 1'b1);
    write_cfg(1, w1, 1'b1);
    write_cfg(2, w2, 1'b1);
    write_cfg(3, w3, 1'b1);
    write_cfg(N, b, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++;
    if ({out_valid0, out_valid1, busy0, busy1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: valid/busy=%b required 0000", {out_valid0, out_valid1, busy0, busy1});
    end
    checks++;
    if ({out_data0, out_data1} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h required 0000", {out_data0, out_data1});
    end
    checks++;
    if ({cfg_ready0, x_ready0, cfg_ready1, x_ready1} !== 4'b1111) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1111", {cfg_ready0, x_ready0, cfg_ready1, x_ready1});
    end
  endtask

  task automatic test_basic();
    int xs [N];
    out_ready = 1'b1;
    load_weights(4, 11, -18, 2, -5);
    xs = '{10, 20, 5, 7};
    send_frame(xs);
    checks++;
    if ({out_valid0, x_ready0, busy0} !== 3'b001) begin
      errors++;
      $display("FAIL basic_act_cycle: valid/x_ready/busy=%b required 001", {out_valid0, x_ready0, busy0});
    end
    step();
    checks++;
    if ({out_valid0, out_valid1} !== 2'b11) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%b required 11", {out_valid0, out_valid1});
    end
    check_result("basic");
    step();
    checks++;
    if ({out_valid0, x_ready0, busy0} !== 3'b010) begin
      errors++;
      $display("FAIL basic_one_cycle: valid/x_ready/busy=%b required 010", {out_valid0, x_ready0, busy0});
    end
  endtask

  task automatic test_negative();
    int xs [N];
    xs = '{0, 0, 10, 0};
    send_frame(xs);
    check_result("negative");
    step();
  endtask

  task automatic test_saturate();
    int xs [N];
    load_weights(100, 100, 100, 100, -5);
    xs = '{127, 127, 127, 127};
    send_frame(xs);
    check_result("saturate");
    step();
  endtask

  task automatic test_backpressure();
    int xs [N];
    out_ready = 1'b0;
    xs = '{1, 2, -1, 1};
    send_frame(xs);
    check_result("bp_first");
    for (int c = 0; c < 5; c++) begin
      x_valid = (c % 2 == 0);
      x_data  = 8'h55;
      step();
      checks++;
      if ({out_valid0, out_valid1, x_ready0, x_ready1} !== 4'b1100 ||
          out_data0 !== e0 || out_data1 !== e1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid/x_ready=%b data=%h/%h required 1100 %h/%h",
                 c, {out_valid0, out_valid1, x_ready0, x_ready1}, out_data0, out_data1, e0, e1);
      end
    end
    x_valid   = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid0, x_ready0} !== 2'b01 || out_data0 !== e0) begin
      errors++;
      $display("FAIL bp_release: valid/x_ready=%b data=%h required 01 %h",
               {out_valid0, x_ready0}, out_data0, e0);
    end
    xs = '{-3, 7, 2, -1};
    send_frame(xs);
    check_result("bp_next");
    step();
  endtask

  task automatic test_mid_reset();
    int xs [N];
    for (int i = 0; i < 2; i++) begin
      x_valid = 1'b1;
      x_data  = 8'd50;
      step();
    end
    x_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid0, out_valid1, busy0, busy1} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_async: valid/busy=%b required 0000", {out_valid0, out_valid1, busy0, busy1});
    end
    for (int i = 0; i < N; i++) w_m[i] = 0;
    bias_m = 0;
    @(negedge clk);
    reset = 1'b1;
    step();
    load_weights(3, -7, 9, 1, 12);
    xs = '{20, -10, 30, 5};
    send_frame(xs);
    check_result("midreset_frame");
    step();
  endtask

  task automatic test_cfg_lock();
    int xs [N];
    load_weights(4, 11, -18, 2, -5);
    write_cfg(7, 77, 1'b0);
    xs = '{10, 20, 5, 7};
    push_expect(xs);
    cfg_we   = 1'b1;
    cfg_addr = 3'd4;
    cfg_data = 8'd99;
    x_valid  = 1'b1;
    x_data   = xs[0][7:0];
    step();
    cfg_we = 1'b0;
    checks++;
    if ({cfg_ready0, busy0} !== 2'b01) begin
      errors++;
      $display("FAIL cfg_lock_ready: cfg_ready/busy=%b required 01", {cfg_ready0, busy0});
    end
    x_data = xs[1][7:0];
    step();
    x_valid  = 1'b0;
    cfg_we   = 1'b1;
    cfg_addr = 3'd3;
    cfg_data = 8'd50;
    step();
    cfg_we = 1'b0;
    for (int i = 2; i < N; i++) begin
      x_valid = 1'b1;
      x_data  = xs[i][7:0];
      step();
    end
    x_valid = 1'b0;
    check_result("cfg_locked");
    step();
    write_cfg(3, 50, 1'b1);
    send_frame(xs);
    check_result("cfg_idle_write");
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    x_valid   = 1'b0;
    x_data    = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) w_m[i] = 0;
    bias_m = 0;
    test_reset();
    test_basic();
    test_negative();
    test_saturate();
    test_backpressure();
    test_mid_reset();
    test_cfg_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_neuron_serial.md
Name: mac_neuron_serial

Overview:
- Parametrised, time-multiplexed neuron: N_IN activations stream in one per cycle and are multiplied by runtime-loadable signed weights.
- Products accumulate with a bias into a wide signed accumulator, then pass through a selectable activation (ReLU-saturate or linear-saturate), shift and clamp.
- Result is presented on a valid/ready output.
- Successor to the fixed 15-input parallel nodes in the ECG classifier layers; one instance serves any layer width.

Parameters:
- N_IN, 15, number of inputs/weights per neuron (>=2)
- DATA_W, 8, activation input width, signed two's complement
- WGT_W, 8, weight and bias width, signed
- ACC_W, 24, accumulator width, signed; wraps modulo 2^ACC_W
- OUT_W, 8, output width
- SHIFT, 5, right shift applied to accumulator before clamp
- ACT_MODE, 0, 0 = ReLU (output unsigned 0..2^OUT_W-1), 1 = linear (output signed -2^(OUT_W-1)..2^(OUT_W-1)-1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_we  in  1  weight/bias write strobe
- cfg_addr  in  clog2(N_IN+1)  0..N_IN-1 selects weight, N_IN selects bias
- cfg_data  in  WGT_W  value written
- cfg_ready  out  1  high when writes are accepted
- x_valid  in  1  input sample valid
- x_data  in  DATA_W  input sample, index implied by arrival order
- x_ready  out  1  block accepts a sample this cycle
- out_valid  out  1  result valid
- out_data  out  OUT_W  activated result
- out_ready  in  1  downstream accepts result
- busy  out  1  high in MAC (idx>0), ACT or OUT

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - State MAC, idx=0, acc=0, out_valid=0, out_data=0.
  - Weights and bias cleared to 0.
- Register file: N_IN weights plus one bias, combinational read by idx.
  - Write occurs on clk when cfg_we & cfg_ready.
  - cfg_ready = ~busy.
  - cfg_addr > N_IN is ignored.
  - A write in the same cycle as the first sample acceptance (idx=0) is ignored; the sample is accepted. cfg_ready drops the next cycle.
- FSM states MAC, ACT, OUT:
  - MAC: x_ready=1. On x_valid:
    - acc <= (idx==0 ? sext(bias) : acc) + sext(w[idx])*sext(x_data), full-precision product truncated to ACC_W.
    - idx <= idx+1.
    - When idx==N_IN-1: idx <= 0, go to ACT.
    - x_valid low stalls with no state change; gaps between samples are allowed.
  - ACT: x_ready=0, one cycle.
    - s = acc >>> SHIFT (arithmetic).
    - Mode 0: s<0 -> 0; s>2^OUT_W-1 -> all ones; else s[OUT_W-1:0].
    - Mode 1: clamp s to the signed OUT_W range.
    - Register into out_data; out_valid <= 1; go to OUT.
  - OUT: x_ready=0, out_valid=1, out_data held stable.
    - On out_ready: out_valid <= 0 and go to MAC the same edge. out_data retains its value.
- Timing:
  - Latency from last sample accepted to out_valid = 2 edges.
  - Minimum period per neuron = N_IN+2 cycles when out_ready is tied high.
- Reset mid-operation aborts the partial sum. The next result uses only samples accepted after reset, with the cleared weights unless they are rewritten.
- Accumulator overflow wraps silently. The ACC_W choice guarantees headroom: DATA_W+WGT_W+clog2(N_IN+1) <= ACC_W for defaults.

Test Plan:
- N_IN=4, mode 0, weights 4,11,-18,2, bias -5, x=10,20,5,7 back-to-back, out_ready=1 -> acc=179, out_data=5, out_valid high for 1 cycle exactly 2 edges after 4th sample.
- Same weights, x=0,0,10,0 -> acc=-185; mode 0 out_data=0; mode 1 out_data=0xFA (-6).
- Weights 100,100,100,100, bias -5, x=127 x4 -> acc=50795; mode 0 out_data=255; mode 1 out_data=127.
- out_ready held low 5 cycles after result -> out_valid and out_data stable, x_ready=0, x_valid pulses ignored. Then out_ready=1 -> next frame accepted from following cycle and result correct.
- Assert reset after 2 of 4 samples -> out_valid=0, busy=0 immediately (asynchronous). Rewrite weights, send a full frame -> result matches a fresh computation.
- cfg_we during MAC (idx=2) writing weight 3=50 -> ignored, result uses old weight. The same write while idle changes the next result.
